// File: rtl/edge_trigger_pkg.sv
// edge_trigger_pkg: edge mode codes and channel FSM state encoding
package edge_trigger_pkg;
  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;
  localparam logic [1:0] MODE_OFF  = 2'b11;
  typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1, HOLD = 2'd2} state_t;
endpackage

// File: rtl/edge_trigger_ch.sv
// edge_trigger_ch: one channel of synchroniser, armed edge detect, pulse/holdoff FSM
module edge_trigger_ch
  import edge_trigger_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PW_W = 8,
  parameter int HOLD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [PW_W-1:0]   pulse_len,
  input  logic [HOLD_W-1:0] holdoff,
  output logic              trigger,
  output logic              drop,
  output logic              trig_nx
);
  logic s, prev, armed, hit;
  state_t state;
  logic [PW_W-1:0] pcnt;
  logic [HOLD_W-1:0] hcnt;
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = start;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sr;
      logic [SYNC_STAGES:0] sh;
      assign sh = {sr, start};
      assign s = sr[SYNC_STAGES-1];
      // shift the level input through the synchroniser flops
      always_ff @(posedge clk)
        sr <= rst ? '0 : sh[SYNC_STAGES-1:0];
    end
  endgenerate
  // an edge only counts once the channel has a valid previous sample
  always_comb
    hit = en && armed && (mode == MODE_RISE ? (s && !prev) :
                          mode == MODE_FALL ? (!s && prev) :
                          mode == MODE_BOTH ? (s ^ prev) : 1'b0);
  assign trig_nx = en && (state == IDLE ? hit : (state == PULSE && pcnt != '0));
  // holdoff is captured into hcnt at pulse start and counted down after the pulse
  always_ff @(posedge clk)
    if (rst || !en) begin
      state <= IDLE;
      trigger <= 1'b0;
      drop <= 1'b0;
      armed <= 1'b0;
      pcnt <= '0;
      hcnt <= '0;
      if (rst) prev <= 1'b0;
    end else begin
      prev <= s;
      armed <= 1'b1;
      if (hit && state != IDLE) drop <= 1'b1;
      case (state)
        IDLE:
          if (hit) begin
            state <= PULSE;
            trigger <= 1'b1;
            pcnt <= pulse_len == '0 ? '0 : pulse_len - 1'b1;
            hcnt <= holdoff;
          end
        PULSE:
          if (pcnt != '0) pcnt <= pcnt - 1'b1;
          else begin
            trigger <= 1'b0;
            state <= hcnt != '0 ? HOLD : IDLE;
            hcnt <= hcnt != '0 ? hcnt - 1'b1 : '0;
          end
        HOLD:
          if (hcnt != '0) hcnt <= hcnt - 1'b1;
          else state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: rtl/edge_trigger_bank.sv
// edge_trigger_bank: N independent edge-trigger channels with a combined trigger flag
module edge_trigger_bank
  import edge_trigger_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PW_W = 8,
  parameter int HOLD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   en,
  input  logic [N_CH-1:0]   start,
  input  logic [2*N_CH-1:0] mode,
  input  logic [PW_W-1:0]   pulse_len,
  input  logic [HOLD_W-1:0] holdoff,
  output logic [N_CH-1:0]   trigger,
  output logic              trigger_any,
  output logic [N_CH-1:0]   drop
);
  logic [N_CH-1:0] trig_nx;
  genvar i;
  generate
    for (i = 0; i < N_CH; i++) begin : g_ch
      edge_trigger_ch #(.SYNC_STAGES(SYNC_STAGES), .PW_W(PW_W), .HOLD_W(HOLD_W)) u_ch (
        .clk(clk), .rst(rst), .en(en[i]), .start(start[i]), .mode(mode[2*i+:2]),
        .pulse_len(pulse_len), .holdoff(holdoff),
        .trigger(trigger[i]), .drop(drop[i]), .trig_nx(trig_nx[i])
      );
    end
  endgenerate
  // register the OR of next-state triggers so it lines up with trigger
  always_ff @(posedge clk)
    trigger_any <= rst ? 1'b0 : |trig_nx;
endmodule

// File: tb/tb_edge_trigger_bank.sv
// tb_edge_trigger_bank: randomized and directed stimulus checked by a scoreboard against a timing model
module tb_edge_trigger_bank;
  localparam int N = 4, SY = 2, PW = 8, HW = 16;
  logic clk = 0, rst = 1;
  logic [N-1:0] en = '0, start = '0;
  logic [2*N-1:0] mode = '0;
  logic [PW-1:0] pulse_len = 8'd1;
  logic [HW-1:0] holdoff = '0;
  logic [N-1:0] trigger, drop;
  logic trigger_any;
  typedef struct {int c; logic [N-1:0] t; logic a; logic [N-1:0] d;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, cyc = 0;
  logic [N-1:0] st_h[$];
  bit rs_h[$];
  bit arm[N], prv[N], drp[N];
  int t_beg[N], t_end[N], b_end[N];

  always #5 clk = ~clk;

  edge_trigger_bank #(.N_CH(N), .SYNC_STAGES(SY), .PW_W(PW), .HOLD_W(HW)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .mode(mode),
    .pulse_len(pulse_len), .holdoff(holdoff),
    .trigger(trigger), .trigger_any(trigger_any), .drop(drop)
  );

  // synchronised sample seen at edge cyc: start from SY edges ago, zero if reset touched the chain
  function automatic bit sync_s(int i);
    if (cyc < SY) return 1'b0;
    for (int k = cyc - SY; k < cyc; k++) if (rs_h[k]) return 1'b0;
    return st_h[cyc-SY][i];
  endfunction

  // expected outputs after the upcoming edge, expressed as accepted-trigger windows
  task automatic model_edge();
    exp_t e;
    bit s, p, hit;
    int len;
    logic [1:0] m;
    st_h.push_back(start);
    rs_h.push_back(rst);
    e.c = cyc;
    for (int i = 0; i < N; i++) begin
      s = sync_s(i);
      p = prv[i];
      m = mode[2*i+:2];
      if (rst) begin
        arm[i] = 0; prv[i] = 0; drp[i] = 0; t_end[i] = -1; b_end[i] = -1;
      end else if (!en[i]) begin
        arm[i] = 0; drp[i] = 0; t_end[i] = -1; b_end[i] = -1;
      end else begin
        hit = arm[i] && (m == 2'd0 ? (s && !p) : m == 2'd1 ? (!s && p) : m == 2'd2 ? (s != p) : 1'b0);
        if (hit && cyc <= b_end[i]) drp[i] = 1;
        else if (hit) begin
          len = pulse_len == 0 ? 1 : int'(pulse_len);
          t_beg[i] = cyc;
          t_end[i] = cyc + len - 1;
          b_end[i] = cyc + len + int'(holdoff);
        end
        prv[i] = s;
        arm[i] = 1;
      end
      e.t[i] = cyc >= t_beg[i] && cyc <= t_end[i];
      e.d[i] = drp[i];
    end
    e.a = |e.t;
    sb.push_back(e);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  // monitor: pop the expectation for each edge and compare outputs
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty time=%0t", $time);
      end else begin
        e = sb.pop_front();
        if (trigger !== e.t) begin errors++; $display("FAIL trigger cyc=%0d got=%b exp=%b", e.c, trigger, e.t); end
        checks++;
        if (trigger_any !== e.a) begin errors++; $display("FAIL trigger_any cyc=%0d got=%b exp=%b", e.c, trigger_any, e.a); end
        checks++;
        if (drop !== e.d) begin errors++; $display("FAIL drop cyc=%0d got=%b exp=%b", e.c, drop, e.d); end
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin t_beg[i] = 0; t_end[i] = -1; b_end[i] = -1; end
    rst = 1; run(3);
    rst = 0; en = '1; mode = '0; pulse_len = 8'd3; holdoff = '0; run(7);
    start[0] = 1; run(8);
    mode[1:0] = 2'b01; run(4);
    start[0] = 0; run(8);
    mode[1:0] = 2'b10; start[0] = 1; run(20);
    start[0] = 0; run(20);
    mode[1:0] = 2'b00; pulse_len = 8'd2; holdoff = 16'd5; run(5);
    start[0] = 1; run(2); start[0] = 0; run(2);
    start[0] = 1; run(2); start[0] = 0; run(4);
    start[0] = 1; run(12);
    start = '1; rst = 1; run(3);
    rst = 0; run(10);
    en = '0; run(3);
    en = '1; run(10);
    start = '0; pulse_len = 8'd10; holdoff = '0; run(6);
    start[1] = 1; run(SY + 2);
    rst = 1; run(1);
    rst = 0; start = '0; run(6);
    mode = {2'b11, 2'b00, 2'b00, 2'b00}; pulse_len = 8'd3; run(4);
    start[0] = 1; start[3] = 1; run(10);
    start = '0; pulse_len = 8'd1; holdoff = '0; mode = '0; run(4);
    for (int k = 0; k < 6; k++) begin start[2] = ~start[2]; run(1); end
    run(4);
    for (int k = 0; k < 2000; k++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 5) == 0) start[i] = ~start[i];
      if ($urandom_range(0, 60) == 0) en[$urandom_range(0, N-1)] ^= 1'b1;
      if ($urandom_range(0, 40) == 0) mode = 8'($urandom);
      if ($urandom_range(0, 25) == 0) pulse_len = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 25) == 0) holdoff = 16'($urandom_range(0, 7));
      rst = $urandom_range(0, 300) == 0;
      run(1);
    end
    rst = 0; run(5);
    #4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
